// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end: fetch queue state, reset vector, queue entry.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fq_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} fetch entries; flush clears it and overrides push/pop.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & ((count_q != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential word fetches over req/ack, buffered for IF, redirect flush.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold_if,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fq_state_t     state_q;
  logic [31:0]   fetch_pc_q, drop_addr_q;
  logic [CW-1:0] count, count_next;
  fetch_entry_t  head, push_entry;
  logic          push, pop;

  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
  assign inst_valid = (count != '0);
  assign inst_out   = head.inst;
  assign pc_out     = head.pc;

  assign pop        = inst_valid & ~hold_if;
  assign push       = (state_q == REQ) & imem_ack & ~redirect;
  assign count_next = count + CW'(push) - CW'(pop);
  assign push_entry = '{pc: fetch_pc_q, inst: imem_rdata};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(redirect),
    .push (push),
    .pop  (pop),
    .din  (push_entry),
    .head (head),
    .count(count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_q <= word_align(redirect_pc);
      unique case (state_q)
        IDLE: state_q <= REQ;
        // An unanswered request must still complete; its answer is thrown away in DROP.
        REQ: begin
          if (!imem_ack) begin
            drop_addr_q <= fetch_pc_q;
            state_q     <= DROP;
          end
        end
        DROP:    state_q <= DROP;
        default: state_q <= IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_next < FULL_CNT) state_q <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
            if (count_next >= FULL_CNT) state_q <= IDLE;
          end
        end
        DROP: begin
          if (imem_ack) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based reference model checked every cycle plus literal pins.
module tb_fetch_queue;
  import mips_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n, redirect, hold_if, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst_out, pc_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Memory responder state
  int lat      = 1;
  int wcnt     = 0;
  bit last_req = 1'b0;
  bit last_ack = 1'b0;

  // Reference model
  fetch_entry_t m_q[$];
  logic [31:0]  m_pc         = RPC;
  logic [31:0]  m_stale_addr = RPC;
  bit           m_req        = 1'b0;
  bit           m_stale      = 1'b0;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .hold_if    (hold_if),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory answers after `lat` cycles of a held request; lat==1 means ack tied high.
  task automatic drive_ack();
    if (!imem_req || last_ack || !last_req) wcnt = 0;
    else wcnt++;
    imem_ack   = (lat == 1) ? 1'b1 : (imem_req && (wcnt >= lat - 1));
    imem_rdata = mem_word(imem_addr);
    last_req   = imem_req;
    last_ack   = imem_ack;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      drive_ack();
    end
  endtask

  task automatic do_reset(input int l);
    rst_n    = 1'b0;
    redirect = 1'b0;
    hold_if  = 1'b0;
    lat      = l;
    step(2);
    rst_n = 1'b1;
  endtask

  // Model: a queue of expected entries plus the next address and whether a response is stale.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_pc         = RPC;
      m_stale_addr = RPC;
      m_req        = 1'b0;
      m_stale      = 1'b0;
    end else begin
      bit acc, popped;
      acc    = m_req && imem_ack;
      popped = (m_q.size() != 0) && !hold_if;
      if (redirect) begin
        m_q.delete();
        if (!m_req) m_req = 1'b1;
        else if (!m_stale && !acc) begin
          m_stale      = 1'b1;
          m_stale_addr = m_pc;
        end
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (acc) begin
          if (m_stale) m_stale = 1'b0;
          else begin
            m_q.push_back('{pc: m_pc, inst: imem_rdata});
            m_pc = m_pc + 32'd4;
          end
        end
        if (popped) void'(m_q.pop_front());
        if (!m_stale) m_req = (m_q.size() < int'(DEPTH));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_req", imem_req, m_req);
      check("cyc_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
      check("cyc_valid", inst_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("cyc_pc", pc_out, m_q[0].pc);
        check("cyc_inst", inst_out, m_q[0].inst);
      end
    end
  end

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; hold_if = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    @(negedge clk);
    drive_ack();
    step(2);
    chk_en = 1'b1;

    // Reset state and back-to-back streaming with ack tied high
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RPC);
    check("rst_valid", inst_valid, 0);
    rst_n = 1'b1;
    step(1);
    check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, 32'hBFC0_0000);
    check("t1_valid0", inst_valid, 0);
    step(1);
    check("t1_valid1", inst_valid, 1);
    check("t1_pc0", pc_out, 32'hBFC0_0000);
    check("t1_inst0", inst_out, mem_word(32'hBFC0_0000));
    step(1);
    check("t1_pc1", pc_out, 32'hBFC0_0004);
    step(1);
    check("t1_pc2", pc_out, 32'hBFC0_0008);

    // IF stall: queue fills to DEPTH and requests stop, then resume without gap
    hold_if = 1'b1;
    step(10);
    check("hold_req", imem_req, 0);
    check("hold_pc", pc_out, 32'hBFC0_0008);
    hold_if = 1'b0;
    step(1);
    check("rel_pc", pc_out, 32'hBFC0_000C);
    check("rel_req", imem_req, 1);
    check("rel_addr", imem_addr, 32'hBFC0_0018);
    step(1);
    check("rel_pc2", pc_out, 32'hBFC0_0010);

    // Slow memory, redirect during the second wait cycle
    do_reset(3);
    step(2);
    redirect = 1'b1; redirect_pc = 32'h0000_1000;
    step(1);
    redirect = 1'b0;
    check("drop_req", imem_req, 1);
    check("drop_addr", imem_addr, 32'hBFC0_0000);
    step(1);
    check("drop_next_addr", imem_addr, 32'h0000_1000);
    check("drop_valid", inst_valid, 0);
    step(3);
    check("drop_first_valid", inst_valid, 1);
    check("drop_first_pc", pc_out, 32'h0000_1000);

    // Redirect coinciding with an ack and a pop
    do_reset(1);
    step(2);
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    step(1);
    redirect = 1'b0;
    check("rdack_valid", inst_valid, 0);
    check("rdack_addr", imem_addr, 32'h0000_3000);
    step(1);
    check("rdack_pc", pc_out, 32'h0000_3000);

    // Misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h0000_2003;
    step(1);
    redirect = 1'b0;
    check("align_addr", imem_addr, 32'h0000_2000);
    step(1);
    check("align_pc", pc_out, 32'h0000_2000);

    // Address wrap at the top of the space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step(1);
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    step(1);
    check("wrap_pc0", pc_out, 32'hFFFF_FFF8);
    step(1);
    check("wrap_pc1", pc_out, 32'hFFFF_FFFC);
    step(1);
    check("wrap_pc2", pc_out, 32'h0000_0000);

    // Mixed stall pattern with two-cycle memory, checked by the model
    lat = 2;
    for (int i = 0; i < 24; i++) begin
      hold_if = ((i % 5) < 2);
      step(1);
    end
    hold_if = 1'b0;

    // Reset while a dropped response is pending
    do_reset(3);
    step(2);
    redirect = 1'b1; redirect_pc = 32'h0000_4000;
    step(1);
    redirect = 1'b0;
    check("rstdrop_addr", imem_addr, 32'hBFC0_0000);
    rst_n = 1'b0;
    step(1);
    check("rstdrop_req", imem_req, 0);
    check("rstdrop_valid", inst_valid, 0);
    rst_n = 1'b1;
    step(1);
    check("rstdrop_req2", imem_req, 1);
    check("rstdrop_addr2", imem_addr, 32'hBFC0_0000);
    step(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
